dm_resp: RTL
============

DM_RESP -- requirements
Module: dm_resp

Interface
REQ-001 Parameter: DEPTH, 1024, number of 32-bit words; word index = Addr[11:2].
REQ-002 Parameter: WAIT_CYCLES, 2, wait states inserted per access when DM_WAIT_EN is defined (range 0..15).
REQ-003 Port: Clk  input  1  single clock; all state changes on posedge Clk.
REQ-004 Port: Reset  input  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-005 Port: Req  input  1  initiator request, valid when high.
REQ-006 Port: We  input  1  1 = write, 0 = read; qualified by Req.
REQ-007 Port: Addr  input  32  byte address of the access.
REQ-008 Port: Be  input  4  byte enables for writes; Be[i] covers Din[8i+7:8i].
REQ-009 Port: Din  input  32  write data.
REQ-010 Port: Ready  output  1  high when a request is accepted this cycle.
REQ-011 Port: Ack  output  1  one-cycle completion pulse.
REQ-012 Port: Err  output  1  error flag, valid only while Ack is high.
REQ-013 Port: Dout  output  32  read data, valid only while Ack is high.

Function
REQ-014 The controller SHALL have three states: IDLE, WAIT, RESP.
REQ-015 Ready SHALL be 1 in IDLE and 0 in WAIT and RESP.
REQ-016 In IDLE, Req=1 at a posedge SHALL latch Addr, We, Be and Din; Req while Ready=0 SHALL be ignored, with no queueing.
REQ-017 After acceptance, the state SHALL go to WAIT when the active wait count is nonzero, else directly to RESP.
REQ-018 WAIT SHALL load a 4-bit counter with WAIT_CYCLES-1 at acceptance, decrement it each cycle, and go to RESP when it reaches 0.
REQ-019 Latency: a request accepted at edge N SHALL raise Ack during cycle N+1+W, where W is the active wait count.
REQ-020 RESP SHALL last exactly one cycle with Ack=1, then return to IDLE; maximum throughput is one access per 2+W cycles.
REQ-021 A read SHALL present mem[Addr[11:2]] on Dout during RESP, sampled at the RESP cycle.
REQ-022 A write SHALL update only bytes with Be[i]=1 on the edge ending RESP; Dout SHALL be 0 during a write Ack.
REQ-023 Read-after-write to the same word in consecutive accesses SHALL return the new data.
REQ-024 Err SHALL be 1 with Ack when Addr[31:12]!=0 or Addr[1:0]!=0; an erroring write SHALL not modify memory, and an erroring read SHALL return Dout=0.
REQ-025 A write with Be=4'b0000 SHALL complete normally with no memory change.
REQ-026 Outside RESP, Ack, Err and Dout SHALL be 0.

Reset
REQ-027 Reset=1 at a posedge SHALL force IDLE, counter=0, Ack=0, Err=0, Dout=0, Ready=1 the next cycle, and clear all DEPTH words to 0.
REQ-028 Reset asserted during WAIT or RESP SHALL abort the access: no Ack and no memory write, including a write whose RESP edge coincides with Reset.
REQ-029 Req is ignored in any cycle where Reset=1.

Configuration
REQ-030 With macro DM_WAIT_EN defined, the active wait count SHALL be W=WAIT_CYCLES.
REQ-031 Without DM_WAIT_EN, W SHALL be 0: the block has no WAIT state or counter, and Ack occurs the cycle after acceptance.

Verification
REQ-032 DM_WAIT_EN, WAIT_CYCLES=2: write Addr=0x10, Be=F, Din=0xDEADBEEF accepted at edge 0 -> Ack in cycle 3, Err=0; a subsequent read of 0x10 -> Dout=0xDEADBEEF with Ack.
REQ-033 Byte enables: after the REQ-032 write, write Be=4'b0101, Din=0x11223344 -> a read of 0x10 returns 0xDE22BE44.
REQ-034 Errors: read Addr=0x1002 -> Ack with Err=1, Dout=0; write Addr=0x13 -> Err=1 and word 0x10 unchanged.
REQ-035 Busy: Req held high continuously -> Ready high only in IDLE cycles; exactly one Ack per 4 cycles with W=2.
REQ-036 Reset mid-write: Reset asserted in the WAIT cycle of a write to 0x20 -> no Ack; the next cycle Ready=1, and a read of 0x20 returns 0.
REQ-037 Without DM_WAIT_EN: read accepted at edge N -> Ack in cycle N+1; back-to-back reads give one Ack every 2 cycles.

Source files
------------

// File: rtl/dm_resp.sv
// dm_resp -- single-port 32-bit data memory responder with a
// request/ready/ack handshake.
//
// Optional feature macro: DM_WAIT_EN
//   defined   : WAIT_CYCLES wait states are inserted between acceptance and
//               the response (IDLE -> WAIT -> RESP).
//   undefined : no WAIT state and no counter (IDLE -> RESP); Ack arrives the
//               cycle after acceptance.
//
// Parameters
//   DEPTH        number of 32-bit words; word index = Addr[11:2]
//   WAIT_CYCLES  wait states per access when DM_WAIT_EN is defined (0..15)
//
// Ports
//   Clk    in   clock, all state changes on the rising edge
//   Reset  in   synchronous active-high reset; also clears the whole memory
//   Req    in   request valid (sampled only while Ready=1)
//   We     in   1 = write, 0 = read
//   Addr   in   [31:0] byte address; Addr[31:12]!=0 or Addr[1:0]!=0 -> Err
//   Be     in   [3:0]  byte enables for writes
//   Din    in   [31:0] write data
//   Ready  out  high in IDLE, i.e. a request is accepted this cycle
//   Ack    out  one-cycle completion pulse (RESP state)
//   Err    out  error flag, valid with Ack
//   Dout   out  [31:0] read data, valid with Ack (0 for writes and errors)
module dm_resp #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        We,
  input  logic [31:0] Addr,
  input  logic [3:0]  Be,
  input  logic [31:0] Din,
  output logic        Ready,
  output logic        Ack,
  output logic        Err,
  output logic [31:0] Dout
);

  localparam int AW = $clog2(DEPTH);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dm_resp: WAIT_CYCLES must be in 0..15");
  end

`ifdef DM_WAIT_EN
  localparam logic [3:0] W_ACT = 4'(WAIT_CYCLES);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
  logic [3:0] cnt;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESP = 2'd2} state_t;
`endif

  state_t         state;
  logic [31:0]    mem [DEPTH];

  // access latched at acceptance
  logic [AW-1:0]  idx_q;
  logic           we_q;
  logic           err_q;
  logic [3:0]     be_q;
  logic [31:0]    din_q;

  // response selection: straight from the inputs when leaving IDLE,
  // from the latched access when leaving WAIT
  logic           err_in;
  logic           go_resp;
  logic [AW-1:0]  r_idx;
  logic           r_we;
  logic           r_err;

  always_comb begin
    err_in  = (|Addr[31:12]) || (|Addr[1:0]);
    r_idx   = Addr[2 +: AW];
    r_we    = We;
    r_err   = err_in;
    go_resp = 1'b0;
`ifdef DM_WAIT_EN
    if (state == S_IDLE) begin
      go_resp = Req && (W_ACT == 4'd0);
    end else if (state == S_WAIT) begin
      go_resp = (cnt == 4'd0);
      r_idx   = idx_q;
      r_we    = we_q;
      r_err   = err_q;
    end
`else
    go_resp = (state == S_IDLE) && Req;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // aborts any access in flight, including a write whose RESP edge
      // coincides with Reset
      state <= S_IDLE;
      Ready <= 1'b1;
      Ack   <= 1'b0;
      Err   <= 1'b0;
      Dout  <= '0;
      idx_q <= '0;
      we_q  <= 1'b0;
      err_q <= 1'b0;
      be_q  <= '0;
      din_q <= '0;
`ifdef DM_WAIT_EN
      cnt   <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // read data is sampled on the edge entering RESP, so a write that
      // committed at the end of the previous RESP is already visible
      if (go_resp) begin
        state <= S_RESP;
        Ack   <= 1'b1;
        Err   <= r_err;
        Dout  <= (r_we || r_err) ? 32'd0 : mem[r_idx];
      end
      case (state)
        S_IDLE: begin
          if (Req) begin
            idx_q <= Addr[2 +: AW];
            we_q  <= We;
            err_q <= err_in;
            be_q  <= Be;
            din_q <= Din;
            Ready <= 1'b0;
`ifdef DM_WAIT_EN
            if (W_ACT != 4'd0) begin
              state <= S_WAIT;
              cnt   <= W_ACT - 4'd1;
            end
`endif
          end
        end
`ifdef DM_WAIT_EN
        S_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
`endif
        S_RESP: begin
          state <= S_IDLE;
          Ready <= 1'b1;
          Ack   <= 1'b0;
          Err   <= 1'b0;
          Dout  <= '0;
          if (we_q && !err_q) begin
            for (int b = 0; b < 4; b++)
              if (be_q[b]) mem[idx_q][8*b +: 8] <= din_q[8*b +: 8];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
